// File: rtl/int_iq_age_matrix_selector.sv
// Integer issue-queue selector: exact age-matrix oldest-first picking for two
// issue ports, with a ctrl-starvation guard on port 0 and a muldiv issue lock.
module int_iq_age_matrix_selector #(
  parameter int IQ_NUM          = 8,
  parameter int IQ_W            = $clog2(IQ_NUM),
  parameter int MULDIV_LOCK_CYC = 3,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IQ_NUM-1:0] entry_valid,
  input  logic [IQ_NUM-1:0] entry_ready,
  input  logic [IQ_NUM-1:0] entry_is_ctrl,
  input  logic [IQ_NUM-1:0] entry_is_muldiv,
  input  logic [IQ_NUM-1:0] entry_is_critical,
  input  logic [IQ_W-1:0]   dispatch_idx0,
  input  logic [IQ_W-1:0]   dispatch_idx1,
  input  logic              dispatch_valid0,
  input  logic              dispatch_valid1,
  input  logic              muldiv_busy,
  input  logic              recovery_flush,
  input  logic              non_posion_issue,
  input  logic              replay_issue_first,
  input  logic              issue_replay,
  input  logic              branch_miss_flush,
  input  logic              load_wake_up_kill,
  input  logic              replay_issue_muldiv,
  output logic              muldiv_issuable,
  output logic [IQ_W-1:0]   issue_idx0,
  output logic [IQ_W-1:0]   issue_idx1,
  output logic              issue_valid0,
  output logic              issue_valid1
);

  localparam int MC_W = $clog2(MULDIV_LOCK_CYC + 1);
  localparam int ST_W = $clog2(STARVE_LIMIT + 1);

  // older[j][i] = 1 means slot j is older than slot i
  logic [IQ_NUM-1:0][IQ_NUM-1:0] older;
  logic [IQ_NUM-1:0][IQ_NUM-1:0] older_nxt;
  logic [MC_W-1:0]               muldiv_cnt;
  logic [MC_W-1:0]               muldiv_cnt_nxt;
  logic [ST_W-1:0]               starve_cnt;
  logic [ST_W-1:0]               starve_cnt_nxt;

  logic              issue_lock;
  logic              md_ok;
  logic              p0_ctl;
  logic [IQ_NUM-1:0] elig;
  logic [IQ_NUM-1:0] alu_set;
  logic [IQ_NUM-1:0] ctl_set;
  logic [IQ_NUM-1:0] md_set;
  logic [IQ_NUM-1:0] alu_rest;
  logic [IQ_W:0]     alu0;
  logic [IQ_W:0]     alu1;
  logic [IQ_W:0]     ctl0;
  logic [IQ_W:0]     md0;

  // Returns {valid, idx} of the member of set with no older member in set.
  function automatic logic [IQ_W:0] pick_oldest(
    input logic [IQ_NUM-1:0]             set,
    input logic [IQ_NUM-1:0][IQ_NUM-1:0] m
  );
    logic [IQ_W:0] r;
    logic          blocked;
    r = '0;
    for (int i = IQ_NUM - 1; i >= 0; i--) begin
      blocked = 1'b0;
      for (int j = 0; j < IQ_NUM; j++) begin
        if (j != i && set[j] && m[j][i]) blocked = 1'b1;
      end
      if (set[i] && !blocked) r = {1'b1, IQ_W'(i)};
    end
    return r;
  endfunction

  always_comb begin
    issue_lock = branch_miss_flush | load_wake_up_kill | issue_replay |
                 (non_posion_issue & replay_issue_first);
    elig     = entry_valid & entry_ready & ~({IQ_NUM{non_posion_issue}} & ~entry_is_critical);
    alu_set  = elig & ~entry_is_ctrl & ~entry_is_muldiv;
    ctl_set  = elig & entry_is_ctrl;
    md_set   = elig & entry_is_muldiv;
    alu0     = pick_oldest(alu_set, older);
    alu_rest = alu_set;
    if (alu0[IQ_W]) alu_rest[alu0[IQ_W-1:0]] = 1'b0;
    alu1     = pick_oldest(alu_rest, older);
    ctl0     = pick_oldest(ctl_set, older);
    md0      = pick_oldest(md_set, older);
  end

  always_comb begin
    md_ok  = (muldiv_cnt == '0) & ~muldiv_busy;
    // ctrl owns port 0 until the displaced ALU entry has waited long enough
    p0_ctl = ctl0[IQ_W] & ((starve_cnt < ST_W'(STARVE_LIMIT)) | ~alu0[IQ_W]);

    muldiv_issuable = ~rst & md_ok;
    issue_valid0    = ~rst & ~issue_lock & (ctl0[IQ_W] | alu0[IQ_W]);
    issue_idx0      = p0_ctl ? ctl0[IQ_W-1:0] : alu0[IQ_W-1:0];
    if (md0[IQ_W] && md_ok) begin
      issue_valid1 = ~rst & ~issue_lock;
      issue_idx1   = md0[IQ_W-1:0];
    end else if (p0_ctl) begin
      issue_valid1 = ~rst & ~issue_lock & alu0[IQ_W];
      issue_idx1   = alu0[IQ_W-1:0];
    end else begin
      issue_valid1 = ~rst & ~issue_lock & alu1[IQ_W];
      issue_idx1   = alu1[IQ_W-1:0];
    end
  end

  always_comb begin
    older_nxt = older;
    if (dispatch_valid0) older_nxt[dispatch_idx0] = '0;
    if (dispatch_valid1) older_nxt[dispatch_idx1] = '0;
    for (int j = 0; j < IQ_NUM; j++) begin
      if (dispatch_valid0 && IQ_W'(j) != dispatch_idx0) older_nxt[j][dispatch_idx0] = 1'b1;
      if (dispatch_valid1 && IQ_W'(j) != dispatch_idx1) older_nxt[j][dispatch_idx1] = 1'b1;
    end
    // instr1 is younger than instr0 within the same dispatch group
    if (dispatch_valid0 && dispatch_valid1) older_nxt[dispatch_idx1][dispatch_idx0] = 1'b0;

    if (issue_lock) begin
      starve_cnt_nxt = starve_cnt;
    end else if (ctl0[IQ_W] && alu0[IQ_W] && p0_ctl) begin
      starve_cnt_nxt = (starve_cnt == ST_W'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + ST_W'(1);
    end else begin
      starve_cnt_nxt = '0;
    end

    if (muldiv_cnt == MC_W'(MULDIV_LOCK_CYC) && !muldiv_busy) begin
      muldiv_cnt_nxt = '0;
    end else if (load_wake_up_kill) begin
      muldiv_cnt_nxt = (muldiv_cnt != '0) ? MC_W'(1) : '0;
    end else if (recovery_flush || (non_posion_issue && replay_issue_first)) begin
      muldiv_cnt_nxt = muldiv_cnt;
    end else if (muldiv_cnt != '0) begin
      muldiv_cnt_nxt = (muldiv_cnt == MC_W'(MULDIV_LOCK_CYC)) ? muldiv_cnt : muldiv_cnt + MC_W'(1);
    end else if ((md0[IQ_W] && !muldiv_busy && !issue_lock) ||
                 (replay_issue_muldiv && issue_replay)) begin
      muldiv_cnt_nxt = MC_W'(1);
    end else begin
      muldiv_cnt_nxt = muldiv_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      older      <= '0;
      muldiv_cnt <= '0;
      starve_cnt <= '0;
    end else begin
      older      <= older_nxt;
      muldiv_cnt <= muldiv_cnt_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_int_iq_age_matrix_selector.sv
// Bench for int_iq_age_matrix_selector: directed scenarios plus random traffic
// checked against a timestamp-based age model.
module tb_int_iq_age_matrix_selector;
  localparam int N  = 8;
  localparam int W  = 3;
  localparam int L  = 3;
  localparam int SL = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] ev, er, ec, em, ecr;
  logic [W-1:0] d0, d1;
  logic         dv0, dv1, busy, rf, npi, rif, ir, bmf, lwk, rim;
  logic         mi, v0, v1;
  logic [W-1:0] i0, i1;

  int n_vec = 0;
  int n_err = 0;

  int unsigned age [N];
  int unsigned seq = 1;
  int          m_starve = 0;
  int          m_mcnt = 0;
  logic        e_v0, e_v1, e_mi;
  logic [W-1:0] e_i0, e_i1;
  logic        m_lock, m_p0ctl, m_ctl0v, m_alu0v, m_md0v;

  int_iq_age_matrix_selector #(.IQ_NUM(N), .IQ_W(W), .MULDIV_LOCK_CYC(L), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .entry_valid(ev), .entry_ready(er), .entry_is_ctrl(ec), .entry_is_muldiv(em),
    .entry_is_critical(ecr),
    .dispatch_idx0(d0), .dispatch_idx1(d1), .dispatch_valid0(dv0), .dispatch_valid1(dv1),
    .muldiv_busy(busy), .recovery_flush(rf), .non_posion_issue(npi),
    .replay_issue_first(rif), .issue_replay(ir), .branch_miss_flush(bmf),
    .load_wake_up_kill(lwk), .replay_issue_muldiv(rim),
    .muldiv_issuable(mi), .issue_idx0(i0), .issue_idx1(i1),
    .issue_valid0(v0), .issue_valid1(v1)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  // Slot with the smallest dispatch timestamp in s, or -1 if s is empty.
  function automatic int oldest(input logic [N-1:0] s);
    int best;
    best = -1;
    for (int i = 0; i < N; i++)
      if (s[i] && (best < 0 || age[i] < age[best])) best = i;
    return best;
  endfunction

  task automatic model_eval();
    logic [N-1:0] elig, alu, ctl, md, alu_r;
    int a0, a1, c0, m0;
    m_lock = bmf | lwk | ir | (npi & rif);
    elig   = ev & er & ~({N{npi}} & ~ecr);
    alu    = elig & ~ec & ~em;
    ctl    = elig & ec;
    md     = elig & em;
    a0     = oldest(alu);
    alu_r  = alu;
    if (a0 >= 0) alu_r[a0] = 1'b0;
    a1     = oldest(alu_r);
    c0     = oldest(ctl);
    m0     = oldest(md);
    m_ctl0v = (c0 >= 0);
    m_alu0v = (a0 >= 0);
    m_md0v  = (m0 >= 0);
    e_mi    = !rst && m_mcnt == 0 && !busy;
    m_p0ctl = m_ctl0v && (m_starve < SL || !m_alu0v);
    e_v0    = !rst && !m_lock && (m_ctl0v || m_alu0v);
    e_i0    = m_p0ctl ? W'(c0) : W'(a0);
    if (m_md0v && e_mi) begin
      e_v1 = !rst && !m_lock;
      e_i1 = W'(m0);
    end else if (m_p0ctl) begin
      e_v1 = !rst && !m_lock && m_alu0v;
      e_i1 = W'(a0);
    end else begin
      e_v1 = !rst && !m_lock && (a1 >= 0);
      e_i1 = W'(a1);
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    int ns, nm;
    model_eval();
    if (rst) begin
      ns = 0;
      nm = 0;
    end else begin
      if (dv0) begin age[d0] = seq; seq++; end
      if (dv1) begin age[d1] = seq; seq++; end
      if (m_lock) ns = m_starve;
      else if (m_ctl0v && m_alu0v && m_p0ctl) ns = (m_starve < SL) ? m_starve + 1 : SL;
      else ns = 0;
      if (m_mcnt == L && !busy) nm = 0;
      else if (lwk) nm = (m_mcnt != 0) ? 1 : 0;
      else if (rf || (npi && rif)) nm = m_mcnt;
      else if (m_mcnt != 0) nm = (m_mcnt < L) ? m_mcnt + 1 : L;
      else if ((m_md0v && !busy && !m_lock) || (rim && ir)) nm = 1;
      else nm = m_mcnt;
    end
    m_starve = ns;
    m_mcnt   = nm;
    @(posedge clk);
    @(negedge clk);
    dv0 = 1'b0;
    dv1 = 1'b0;
  endtask

  task automatic clear_in();
    ev = '0; er = '0; ec = '0; em = '0; ecr = '0;
    d0 = '0; d1 = '0; dv0 = 1'b0; dv1 = 1'b0;
    busy = 1'b0; rf = 1'b0; npi = 1'b0; rif = 1'b0; ir = 1'b0;
    bmf = 1'b0; lwk = 1'b0; rim = 1'b0;
  endtask

  task automatic disp(input int a);
    d0  = W'(a);
    dv0 = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1'b1;
    ev = 8'hFF; er = 8'hFF;
    @(negedge clk);
    settle();
    n_vec++;
    if (v0 !== 1'b0 || v1 !== 1'b0 || mi !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v0=%b v1=%b mi=%b want 0 0 0", v0, v1, mi);
    end
    tick();
    tick();
    rst = 1'b0;
    clear_in();
    settle();
    n_vec++;
    if (mi !== 1'b1 || v0 !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset: got mi=%b v0=%b want mi=1 v0=0", mi, v0);
    end
    tick();
  endtask

  task automatic test_age_order();
    clear_in();
    disp(5); disp(2); disp(7);
    ev = 8'b1010_0100; er = ev;
    settle();
    n_vec++;
    if (v0 !== 1'b1 || i0 !== 3'd5 || v1 !== 1'b1 || i1 !== 3'd2) begin
      n_err++;
      $display("FAIL age_order_3: got v0=%b i0=%0d v1=%b i1=%0d want 1 5 1 2", v0, i0, v1, i1);
    end
    tick();
    ev = 8'b1000_0000; er = ev;
    settle();
    n_vec++;
    if (v0 !== 1'b1 || i0 !== 3'd7 || v1 !== 1'b0) begin
      n_err++;
      $display("FAIL age_order_1: got v0=%b i0=%0d v1=%b want 1 7 0", v0, i0, v1);
    end
    tick();
  endtask

  task automatic test_dual_dispatch();
    clear_in();
    d0 = 3'd3; d1 = 3'd1; dv0 = 1'b1; dv1 = 1'b1;
    tick();
    ev = 8'b0000_1010; er = ev;
    settle();
    n_vec++;
    if (v0 !== 1'b1 || i0 !== 3'd3 || v1 !== 1'b1 || i1 !== 3'd1) begin
      n_err++;
      $display("FAIL dual_dispatch: got v0=%b i0=%0d v1=%b i1=%0d want 1 3 1 1", v0, i0, v1, i1);
    end
    tick();
  endtask

  task automatic test_starve();
    clear_in();
    disp(0); disp(1); disp(4);
    ev = 8'b0001_0011; er = ev; ec = 8'b0001_0000;
    for (int c = 1; c <= 4; c++) begin
      settle();
      n_vec++;
      if (v0 !== 1'b1 || i0 !== 3'd4 || v1 !== 1'b1 || i1 !== 3'd0) begin
        n_err++;
        $display("FAIL starve_ctrl_c%0d: got i0=%0d i1=%0d want 4 0", c, i0, i1);
      end
      tick();
    end
    settle();
    n_vec++;
    if (v0 !== 1'b1 || i0 !== 3'd0 || v1 !== 1'b1 || i1 !== 3'd1) begin
      n_err++;
      $display("FAIL starve_alu: got i0=%0d i1=%0d want 0 1", i0, i1);
    end
    tick();
    settle();
    n_vec++;
    if (v0 !== 1'b1 || i0 !== 3'd4) begin
      n_err++;
      $display("FAIL starve_cleared: got i0=%0d want 4", i0);
    end
    tick();
  endtask

  task automatic test_muldiv_lock();
    clear_in();
    disp(6); disp(2);
    ev = 8'b0100_0100; er = ev; em = ev;
    settle();
    n_vec++;
    if (mi !== 1'b1 || v1 !== 1'b1 || i1 !== 3'd6 || v0 !== 1'b0) begin
      n_err++;
      $display("FAIL muldiv_first: got mi=%b v1=%b i1=%0d v0=%b want 1 1 6 0", mi, v1, i1, v0);
    end
    tick();
    ev = 8'b0000_0100; er = ev; em = ev;
    for (int c = 2; c <= 4; c++) begin
      settle();
      n_vec++;
      if (mi !== 1'b0 || v1 !== 1'b0) begin
        n_err++;
        $display("FAIL muldiv_locked_c%0d: got mi=%b v1=%b want 0 0", c, mi, v1);
      end
      tick();
    end
    settle();
    n_vec++;
    if (mi !== 1'b1 || v1 !== 1'b1 || i1 !== 3'd2) begin
      n_err++;
      $display("FAIL muldiv_second: got mi=%b v1=%b i1=%0d want 1 1 2", mi, v1, i1);
    end
    tick();
  endtask

  task automatic test_flush();
    clear_in();
    ev = 8'b0001_0011; er = ev; ec = 8'b0001_0000;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_vec++;
      if (v0 !== 1'b1 || i0 !== 3'd4) begin
        n_err++;
        $display("FAIL flush_pre_c%0d: got v0=%b i0=%0d want 1 4", c, v0, i0);
      end
      tick();
    end
    bmf = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_vec++;
      if (v0 !== 1'b0 || v1 !== 1'b0) begin
        n_err++;
        $display("FAIL flush_gate_c%0d: got v0=%b v1=%b want 0 0", c, v0, v1);
      end
      tick();
    end
    bmf = 1'b0;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_vec++;
      if (v0 !== 1'b1 || i0 !== 3'd4) begin
        n_err++;
        $display("FAIL flush_post_c%0d: got i0=%0d want 4", c, i0);
      end
      tick();
    end
    settle();
    n_vec++;
    if (v0 !== 1'b1 || i0 !== 3'd0) begin
      n_err++;
      $display("FAIL flush_starve_held: got i0=%0d want 0", i0);
    end
    tick();
  endtask

  task automatic test_lwk_nonpoison();
    clear_in();
    tick(); tick(); tick();
    ev = 8'b0100_0000; er = ev; em = ev;
    settle();
    n_vec++;
    if (mi !== 1'b1 || v1 !== 1'b1 || i1 !== 3'd6) begin
      n_err++;
      $display("FAIL lwk_md_issue: got mi=%b v1=%b i1=%0d want 1 1 6", mi, v1, i1);
    end
    tick();
    clear_in();
    tick();
    lwk = 1'b1;
    settle();
    n_vec++;
    if (v0 !== 1'b0 || v1 !== 1'b0 || mi !== 1'b0) begin
      n_err++;
      $display("FAIL lwk_lock: got v0=%b v1=%b mi=%b want 0 0 0", v0, v1, mi);
    end
    tick();
    lwk = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_vec++;
      if (mi !== 1'b0) begin
        n_err++;
        $display("FAIL lwk_rewind_k%0d: got mi=%b want 0", k, mi);
      end
      tick();
    end
    settle();
    n_vec++;
    if (mi !== 1'b1) begin
      n_err++;
      $display("FAIL lwk_release: got mi=%b want 1", mi);
    end
    tick();
    clear_in();
    npi = 1'b1;
    ev = 8'b0000_1011; er = ev; ecr = 8'b0000_1000;
    settle();
    n_vec++;
    if (v0 !== 1'b1 || i0 !== 3'd3 || v1 !== 1'b0) begin
      n_err++;
      $display("FAIL non_poison: got v0=%b i0=%0d v1=%b want 1 3 0", v0, i0, v1);
    end
    tick();
  endtask

  task automatic test_random();
    int perm [N];
    int t, k, a, b;
    clear_in();
    for (int i = 0; i < N; i++) perm[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      k = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[k]; perm[k] = t;
    end
    for (int i = 0; i < N; i++) disp(perm[i]);
    for (int c = 0; c < 400; c++) begin
      ev   = N'($urandom);
      er   = N'($urandom | $urandom);
      ec   = N'($urandom & $urandom);
      em   = N'($urandom & $urandom) & ~ec;
      ecr  = N'($urandom);
      busy = ($urandom_range(3, 0) == 0);
      rf   = ($urandom_range(9, 0) == 0);
      npi  = ($urandom_range(5, 0) == 0);
      rif  = ($urandom_range(5, 0) == 0);
      ir   = ($urandom_range(11, 0) == 0);
      bmf  = ($urandom_range(11, 0) == 0);
      lwk  = ($urandom_range(11, 0) == 0);
      rim  = ($urandom_range(3, 0) == 0);
      k    = int'($urandom_range(3, 0));
      a    = int'($urandom_range(N - 1, 0));
      b    = (a + 1 + int'($urandom_range(N - 2, 0))) % N;
      d0   = W'(a);
      d1   = W'(b);
      dv0  = (k == 1 || k == 2);
      dv1  = (k == 2);
      settle();
      n_vec++;
      if (v0 !== e_v0 || v1 !== e_v1 || mi !== e_mi) begin
        n_err++;
        $display("FAIL rand_valid_c%0d: got v0=%b v1=%b mi=%b want %b %b %b",
                 c, v0, v1, mi, e_v0, e_v1, e_mi);
      end
      if (e_v0) begin
        n_vec++;
        if (i0 !== e_i0) begin
          n_err++;
          $display("FAIL rand_idx0_c%0d: got %0d want %0d", c, i0, e_i0);
        end
      end
      if (e_v1) begin
        n_vec++;
        if (i1 !== e_i1) begin
          n_err++;
          $display("FAIL rand_idx1_c%0d: got %0d want %0d", c, i1, e_i1);
        end
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) age[i] = 0;
    test_reset();
    test_age_order();
    test_dual_dispatch();
    test_starve();
    test_muldiv_lock();
    test_flush();
    test_lwk_nonpoison();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/int_iq_age_matrix_selector.md
Name: int_iq_age_matrix_selector

Overview:
Parametrised integer issue-queue selector for Falco. Picks up to two ready entries per cycle for issue port 0 (ctrl/CSR or ALU) and port 1 (muldiv or ALU). Replaces saturating per-entry age counters with an exact age matrix, so ordering is strictly oldest-first with no saturation ties. Adds a ctrl-starvation guard and a parametrised muldiv issue lock. Sits between the int issue queue slot array and the int execute stage.

Parameters:
IQ_NUM, 8, issue-queue depth; power of 2, from 4 to 32.
IQ_W, $clog2(IQ_NUM), slot index width.
MULDIV_LOCK_CYC, 3, cycles during which a further muldiv issue is blocked after one muldiv issue.
STARVE_LIMIT, 4, consecutive cycles an ALU entry may be displaced from port 0 by ctrl before it takes priority.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
entry_valid  in  IQ_NUM  slot occupied
entry_ready  in  IQ_NUM  operands ready
entry_is_ctrl  in  IQ_NUM  branch/jump or CSR
entry_is_muldiv  in  IQ_NUM  mul/div
entry_is_critical  in  IQ_NUM  may issue under non-poison mode
dispatch_idx0, dispatch_idx1  in  IQ_W  slots written this cycle
dispatch_valid0, dispatch_valid1  in  1  dispatch strobes; instr1 is younger than instr0
muldiv_busy  in  1  muldiv unit cannot accept
recovery_flush, non_posion_issue, replay_issue_first, issue_replay, branch_miss_flush, load_wake_up_kill, replay_issue_muldiv  in  1  issue-control qualifiers
muldiv_issuable  out  1  muldiv may issue this cycle
issue_idx0, issue_idx1  out  IQ_W  selected slots
issue_valid0, issue_valid1  out  1  selection valid

Behaviour:
- One clock (clk). Synchronous active-high reset (rst). Outputs are combinational from state and inputs. While rst=1, all issue outputs are 0 and muldiv_issuable=0.
- State: older[IQ_NUM][IQ_NUM] bit matrix (older[j][i]=1 means j is older than i), muldiv_cnt (width $clog2(MULDIV_LOCK_CYC+1)), starve_cnt ($clog2(STARVE_LIMIT+1) bits). All reset to 0.
- Dispatch of slot d: next-cycle older[j][d]=1 for all j≠d, and older[d][j]=0. On dual dispatch: older[idx0][idx1]=1 and older[idx1][idx0]=0. A dispatched slot's column write overrides any concurrent update. Matrix bits of invalid slots are don't-care because they are masked by the candidate sets.
- issue_lock = branch_miss_flush | load_wake_up_kill | issue_replay | (non_posion_issue & replay_issue_first).
- Candidate base: elig[i] = valid & ready & ~(non_posion_issue & ~critical). alu = elig & ~ctrl & ~muldiv. ctl = elig & ctrl. md = elig & muldiv.
- Oldest of set S: the unique i in S with no j in S where older[j][i]. Second oldest: oldest of S minus the first. Pickers: alu0, alu1, ctl0, md0.
- muldiv_issuable = (muldiv_cnt==0) & ~muldiv_busy.
- Port 0: if ctl0 valid and starve_cnt<STARVE_LIMIT, select ctl0; else select alu0 if valid, else ctl0.
- Port 1: if md0 valid and muldiv_issuable, select md0. Otherwise select the next ALU pick not taken by port 0 (alu0 if port 0 took ctrl, else alu1).
- Both valids are gated by ~issue_lock. Port 0 and port 1 never select the same slot.
- starve_cnt: increments (saturating at STARVE_LIMIT) when ~issue_lock, ctl0 valid, alu0 valid, and port 0 selected ctrl. Resets to 0 when port 0 selects ALU, or when no ALU candidate exists. Holds while issue_lock=1.
- muldiv_cnt priority order:
  1. cnt==MULDIV_LOCK_CYC & ~muldiv_busy → 0.
  2. load_wake_up_kill → (cnt≠0 ? 1 : 0).
  3. recovery_flush | (non_posion_issue & replay_issue_first) → hold.
  4. cnt≠0 → saturating +1.
  5. (md0 valid & ~muldiv_busy & ~issue_lock) | (replay_issue_muldiv & issue_replay) → 1.
  6. Otherwise hold.
- Empty queue: all valids 0 and no state change except from dispatch.
- Reset mid-operation clears the matrix, so entries dispatched before reset have no defined order. The queue is flushed together with rst.

Test Plan:
- Dispatch slots 5, 2, 7 in successive cycles, all ALU and ready → issue_idx0=5, issue_idx1=2; after slots 5 and 2 invalidate, issue_idx0=7 and issue_valid1=0.
- Same-cycle dispatch idx0=3, idx1=1, both ALU → issue_idx0=3, issue_idx1=1.
- Ctrl slot 4 ready every cycle plus ALU slots 0 and 1 → ctrl wins for 4 cycles; cycle 5 port 0 issues the oldest ALU slot and starve_cnt returns to 0.
- Muldiv slots 6 and 2 ready, muldiv_busy=0 → slot 6 issues on port 1; muldiv_issuable stays 0 for 3 cycles; slot 2 issues in cycle 5.
- branch_miss_flush=1 with ALU slots ready → issue_valid0=issue_valid1=0 and starve_cnt holds.
- load_wake_up_kill with muldiv_cnt=2 → muldiv_cnt=1 next cycle; non_posion_issue=1 masks non-critical entries and only the critical slot 3 issues.
